// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch: FSM states, counter width and wrap value.
// Combinational helpers only; no clocked logic here.
package stopwatch_pkg;

    localparam int COUNT_W   = 14;
    localparam int MAX_COUNT = 9999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    // Decimal display range is 000.0..999.9, so the count wraps rather than saturating.
    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] value);
        return (value >= COUNT_W'(MAX_COUNT)) ? '0 : value + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw button -> 2-FF sync -> debounce -> one-cycle pulse on accepted rising edge.
// Pulse appears 2 + DEBOUNCE_CYCLES edges after the raw rise; no backpressure.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    logic w_differs;
    logic w_accept;

    assign w_differs = (r_sync2 != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // Any cycle where the synchronized level agrees restarts the stability window.
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pulse <= w_accept && r_sync2;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: tenths-of-a-second counter 0..9999 with start/stop, clear and lap freeze.
// Buttons act one edge after their conditioned pulse; display is registered from next-state values.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_start_stop,
    input  logic               btn_clear,
    input  logic               btn_lap,
    output logic [COUNT_W-1:0] displayed_number,
    output logic               running,
    output logic               lap_active
);

    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PRE_W    = $clog2(DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic w_ss_p;
    logic w_clr_p;
    logic w_lap_p;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_start_stop),
        .o_pulse (w_ss_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clear),
        .o_pulse (w_clr_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_lap),
        .o_pulse (w_lap_p)
    );

    state_t             r_state;
    logic [PRE_W-1:0]   r_presc;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_lap_reg;
    logic               r_lap_active;
    logic [COUNT_W-1:0] r_displayed;
    logic               r_running;

    state_t             w_state_nxt;
    logic [PRE_W-1:0]   w_presc_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [COUNT_W-1:0] w_lap_reg_nxt;
    logic               w_lap_active_nxt;

    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = r_presc;
        w_count_nxt      = r_count;
        w_lap_reg_nxt    = r_lap_reg;
        w_lap_active_nxt = r_lap_active;

        if (w_clr_p) begin
            w_state_nxt      = IDLE;
            w_presc_nxt      = '0;
            w_count_nxt      = '0;
            w_lap_reg_nxt    = '0;
            w_lap_active_nxt = 1'b0;
        end else begin
            // Prescaler holds outside RUNNING so a resume keeps the partial tenth.
            if (r_state == RUNNING) begin
                if (r_presc == PRE_LAST) begin
                    w_presc_nxt = '0;
                    w_count_nxt = count_inc(r_count);
                end else begin
                    w_presc_nxt = r_presc + PRE_W'(1);
                end
            end

            // Lap and start/stop both look at the current state, so they compose in one cycle.
            if (w_lap_p) begin
                case (r_state)
                    RUNNING: begin
                        if (!r_lap_active) begin
                            w_lap_reg_nxt    = r_count;
                            w_lap_active_nxt = 1'b1;
                        end else begin
                            w_lap_active_nxt = 1'b0;
                        end
                    end
                    PAUSED:  w_lap_active_nxt = 1'b0;
                    default: ;
                endcase
            end

            if (w_ss_p) begin
                case (r_state)
                    IDLE:    w_state_nxt = RUNNING;
                    RUNNING: w_state_nxt = PAUSED;
                    PAUSED:  w_state_nxt = RUNNING;
                    default: w_state_nxt = IDLE;
                endcase
            end

            if ((r_state != IDLE) && (r_state != RUNNING) && (r_state != PAUSED)) begin
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_count      <= '0;
            r_lap_reg    <= '0;
            r_lap_active <= 1'b0;
            r_displayed  <= '0;
            r_running    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_presc      <= w_presc_nxt;
            r_count      <= w_count_nxt;
            r_lap_reg    <= w_lap_reg_nxt;
            r_lap_active <= w_lap_active_nxt;
            r_displayed  <= w_lap_active_nxt ? w_lap_reg_nxt : w_count_nxt;
            r_running    <= (w_state_nxt == RUNNING);
        end
    end

    assign displayed_number = r_displayed;
    assign running          = r_running;
    assign lap_active       = r_lap_active;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: DIV=10, debounce 4; a second DIV=2 instance covers the 9999 wrap.
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_clr = 1'b0;
    logic        btn_lap = 1'b0;
    logic [13:0] disp;
    logic        run;
    logic        lap;

    logic        btn2_ss = 1'b0;
    logic        btn2_clr = 1'b0;
    logic        btn2_lap = 1'b0;
    logic [13:0] disp2;
    logic        run2;
    logic        lap2;

    int n_checks = 0;
    int n_fail   = 0;
    int run_toggles = 0;
    logic run_prev = 1'b0;

    always #5 clk = ~clk;

    stopwatch_counter #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_start_stop   (btn_ss),
        .btn_clear        (btn_clr),
        .btn_lap          (btn_lap),
        .displayed_number (disp),
        .running          (run),
        .lap_active       (lap)
    );

    stopwatch_counter #(.CLK_HZ(20), .TICK_HZ(10), .DEBOUNCE_CYCLES(4)) dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .btn_start_stop   (btn2_ss),
        .btn_clear        (btn2_clr),
        .btn_lap          (btn2_lap),
        .displayed_number (disp2),
        .running          (run2),
        .lap_active       (lap2)
    );

    always @(negedge clk) begin
        if (run !== run_prev) run_toggles = run_toggles + 1;
        run_prev = run;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input logic want, input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            cycles++;
            if (run === want) ok = 1'b1;
        end
    endtask

    task automatic press_clear();
        btn_clr = 1'b1;
        step(8);
        btn_clr = 1'b0;
        step(10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_checks++; if (disp !== 14'd0) begin n_fail++; $display("FAIL reset_disp: got %0d want 0", disp); end
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", run); end
        n_checks++; if (lap !== 1'b0) begin n_fail++; $display("FAIL reset_lap: got %b want 0", lap); end
        rst = 1'b0;
        step(10);
        n_checks++; if (disp !== 14'd0 || run !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: disp=%0d run=%b want 0/0", disp, run); end
    endtask

    task automatic test_start();
        bit ok;
        int cyc;
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL start_timeout: running never rose"); end
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL press_latency: got %0d cycles want 7", cyc); end
        btn_ss = 1'b0;
        n_checks++; if (disp !== 14'd0) begin n_fail++; $display("FAIL start_disp0: got %0d want 0", disp); end
        step(9);
        n_checks++; if (disp !== 14'd0) begin n_fail++; $display("FAIL tick_early: got %0d want 0 at cycle 9", disp); end
        step(1);
        n_checks++; if (disp !== 14'd1) begin n_fail++; $display("FAIL first_tick: got %0d want 1 at cycle 10", disp); end
        step(40);
        n_checks++; if (disp !== 14'd5) begin n_fail++; $display("FAIL tick_50: got %0d want 5", disp); end
    endtask

    task automatic test_bounce();
        int widths[6] = '{1, 3, 2, 1, 3, 2};
        int t0;
        step(10);
        t0 = run_toggles;
        foreach (widths[k]) begin
            btn_ss = 1'b1;
            step(widths[k]);
            btn_ss = 1'b0;
            step(1);
        end
        step(12);
        n_checks++; if (run !== 1'b1 || run_toggles != t0) begin n_fail++; $display("FAIL bounce_reject: run=%b toggles=%0d want 1/0", run, run_toggles - t0); end
        btn_ss = 1'b1;
        step(20);
        btn_ss = 1'b0;
        step(12);
        n_checks++; if (run !== 1'b0 || run_toggles != t0 + 1) begin n_fail++; $display("FAIL held_one_pulse: run=%b toggles=%0d want 0/1", run, run_toggles - t0); end
    endtask

    task automatic test_pause_resume();
        bit ok;
        int cyc;
        press_clear();
        n_checks++; if (run !== 1'b0 || disp !== 14'd0) begin n_fail++; $display("FAIL clear_from_paused: run=%b disp=%0d want 0/0", run, disp); end
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        btn_ss = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pause_start_timeout: running never rose"); end
        step(29);
        btn_ss = 1'b1;
        step(7);
        n_checks++; if (run !== 1'b0 || disp !== 14'd3) begin n_fail++; $display("FAIL pause_enter: run=%b disp=%0d want 0/3", run, disp); end
        btn_ss = 1'b0;
        step(20);
        n_checks++; if (disp !== 14'd3) begin n_fail++; $display("FAIL pause_hold: got %0d want 3", disp); end
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        btn_ss = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL resume_timeout: running never rose"); end
        step(3);
        n_checks++; if (disp !== 14'd3) begin n_fail++; $display("FAIL resume_early: got %0d want 3", disp); end
        step(1);
        n_checks++; if (disp !== 14'd4) begin n_fail++; $display("FAIL resume_tick: got %0d want 4", disp); end
    endtask

    task automatic test_lap();
        bit ok;
        int cyc;
        press_clear();
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        btn_ss = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lap_start_timeout: running never rose"); end
        step(119);
        btn_lap = 1'b1;
        step(7);
        n_checks++; if (lap !== 1'b1 || disp !== 14'd12) begin n_fail++; $display("FAIL lap_capture: lap=%b disp=%0d want 1/12", lap, disp); end
        step(4);
        btn_lap = 1'b0;
        step(69);
        btn_lap = 1'b1;
        step(6);
        n_checks++; if (lap !== 1'b1 || disp !== 14'd12) begin n_fail++; $display("FAIL lap_frozen: lap=%b disp=%0d want 1/12", lap, disp); end
        step(1);
        n_checks++; if (lap !== 1'b0 || disp !== 14'd20) begin n_fail++; $display("FAIL lap_release: lap=%b disp=%0d want 0/20", lap, disp); end
        step(4);
        btn_lap = 1'b0;
        step(15);
        btn_clr = 1'b1;
        btn_lap = 1'b1;
        step(7);
        n_checks++; if (run !== 1'b0 || disp !== 14'd0 || lap !== 1'b0) begin n_fail++; $display("FAIL clear_lap_same: run=%b disp=%0d lap=%b want 0/0/0", run, disp, lap); end
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        step(12);
        n_checks++; if (disp !== 14'd0 || lap !== 1'b0) begin n_fail++; $display("FAIL idle_lap_ignored: disp=%0d lap=%b want 0/0", disp, lap); end
    endtask

    task automatic test_wrap();
        bit found;
        int guard;
        btn2_ss = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (run2 === 1'b1) found = 1'b1;
        end
        btn2_ss = 1'b0;
        n_checks++; if (!found) begin n_fail++; $display("FAIL wrap_start_timeout: running never rose"); end
        found = 1'b0;
        guard = 0;
        while (!found && guard < 25000) begin
            @(negedge clk);
            guard++;
            if (disp2 === 14'd9999) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL wrap_reach_9999: last disp=%0d want 9999", disp2); end
        step(1);
        n_checks++; if (disp2 !== 14'd9999) begin n_fail++; $display("FAIL wrap_hold: got %0d want 9999", disp2); end
        step(1);
        n_checks++; if (disp2 !== 14'd0 || run2 !== 1'b1 || lap2 !== 1'b0) begin n_fail++; $display("FAIL wrap_zero: disp=%0d run=%b lap=%b want 0/1/0", disp2, run2, lap2); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int cyc;
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        btn_ss = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_start_timeout: running never rose"); end
        step(370);
        n_checks++; if (disp !== 14'd37) begin n_fail++; $display("FAIL pre_rst_count: got %0d want 37", disp); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (disp !== 14'd0 || run !== 1'b0 || lap !== 1'b0) begin n_fail++; $display("FAIL async_rst: disp=%0d run=%b lap=%b want 0/0/0", disp, run, lap); end
        @(negedge clk);
        rst = 1'b0;
        step(30);
        n_checks++; if (disp !== 14'd0 || run !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: disp=%0d run=%b want 0/0", disp, run); end
        btn_ss = 1'b1;
        wait_run(1'b1, 20, ok, cyc);
        btn_ss = 1'b0;
        n_checks++; if (!ok || cyc !== 7) begin n_fail++; $display("FAIL post_rst_press: ok=%b cycles=%0d want 1/7", ok, cyc); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_pause_resume();
        test_lap();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Stopwatch core that produces the 14-bit decimal value shown on the board's 4-digit 7-segment display. It counts tenths of a second from 000.0 to 999.9, with the decimal point fixed on the third digit. It is controlled by three raw push-buttons: start/stop, clear and lap. Its `displayed_number` output drives the display multiplexer directly; it sits immediately upstream of that multiplexer.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: clk frequency in Hz.
- `TICK_HZ`, default 10: count rate. `DIV = CLK_HZ/TICK_HZ`; `DIV` must be an integer ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: number of cycles a synchronized button level must stay stable before it is accepted.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high; clock is `clk`.
- `btn_start_stop` in 1: raw button, active-high, asynchronous to clk.
- `btn_clear` in 1: raw button, active-high, asynchronous.
- `btn_lap` in 1: raw button, active-high, asynchronous.
- `displayed_number` out 14: value to display, range 0..9999, registered.
- `running` out 1: high in RUNNING state.
- `lap_active` out 1: high while the display is frozen on a lap value.

## Operation
- **Button conditioning, per button:**
  - 2-FF synchronizer.
  - Debounce: the accepted level updates only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Rising edge of the accepted level gives a 1-cycle pulse: `ss_p`, `clr_p`, `lap_p`.
- **States:** IDLE, RUNNING, PAUSED.
  - IDLE + `ss_p` → RUNNING.
  - RUNNING + `ss_p` → PAUSED.
  - PAUSED + `ss_p` → RUNNING.
  - `clr_p` in any state → IDLE; `count`, prescaler, `lap_reg` and `lap_active` all go to 0.
- **Prescaler:** 0..`DIV-1`, advances only in RUNNING, holds its value in PAUSED so the fractional tick is preserved.
  - When the prescaler equals `DIV-1` in RUNNING, it wraps to 0 and `count` increments on the same edge.
- **Count:** 14-bit, 0..9999. 9999 + tick → 0 (wrap, keeps running). Values above 9999 are never produced.
- **Lap:**
  - RUNNING, `lap_active`=0, `lap_p`: `lap_reg` ← `count` (pre-increment value if a tick coincides), `lap_active` ← 1.
  - RUNNING, `lap_active`=1, `lap_p`: `lap_active` ← 0.
  - PAUSED, `lap_p`: `lap_active` ← 0.
  - IDLE, `lap_p`: ignored.
  - Counting continues while the lap is shown.
- **Simultaneous events:**
  - `clr_p` has priority; any `ss_p` or `lap_p` in the same cycle is discarded.
  - `ss_p` and `lap_p` together: the state transition and the lap action are both evaluated against the current state.
- **Output:** `displayed_number` ← `lap_active_next ? lap_reg_next : count_next`, registered.

## Timing
- **Reset:** `displayed_number`=0, `running`=0, `lap_active`=0, state IDLE, prescaler 0, debounce counters 0, accepted levels 0.
- **Press latency:** raw rise → 2 sync cycles + `DEBOUNCE_CYCLES` → pulse (1 cycle) → state and outputs updated on the next edge.
- **Tick latency:** first increment occurs `DIV` cycles after entering RUNNING from a zero prescaler. `displayed_number` reflects it on the same edge.
- **Glitches:** bounces shorter than `DEBOUNCE_CYCLES` produce no pulse. A held button produces exactly one pulse.
- **rst mid-operation:** everything returns to reset values immediately; the asynchronous assert is immediate and deassertion is synchronous-safe through the existing reset scheme.

## Structure
- **Package `stopwatch_pkg`:**
  - State enum (IDLE, RUNNING, PAUSED).
  - `MAX_COUNT` = 9999.
  - `COUNT_W` = 14.
- **Sub-module `button_conditioner`:** synchronizer + debounce + rising-edge pulse, parameter `DEBOUNCE_CYCLES`, instantiated 3×.
- **Top level:** prescaler, FSM, count, lap logic.

## Test plan
Bench uses `CLK_HZ`=100, `TICK_HZ`=10 (`DIV`=10), `DEBOUNCE_CYCLES`=4.
- **Reset, then start:** reset, one start press → `running`=1; `displayed_number` = 1 exactly 10 cycles later; 5 after 50 cycles.
- **Bounce rejection:** `btn_start_stop` toggled with 1–3-cycle pulses → no state change. Held 20 cycles → exactly one transition.
- **Pause/resume:** stop at prescaler 6 with count 3 → count holds at 3 in PAUSED. Resume → count becomes 4 after 4 more cycles.
- **Wrap:** preset-run to 9999 → next tick gives 0 with `running` still 1.
- **Lap:**
  - Lap at count 12 → display frozen at 12 while internal count reaches 20.
  - Second lap → display 20 (live) and `lap_active`=0.
  - Clear + lap in the same cycle → IDLE, display 0, `lap_active`=0.
- **Async reset:** rst mid-RUNNING at count 37 → all outputs 0 immediately. After release, start needs a new press.
